// File: rtl/kyber_pkg.sv
// Shared types and constants for the Kyber byte/bit stream blocks.
// The entry struct carries a running frame XOR only when BTB_XOR_EN is defined.
package kyber_pkg;

  localparam int KYBER_N = 256;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    DRAIN
  } btb_state_e;

  typedef struct packed {
`ifdef BTB_XOR_EN
    logic [BYTE_W-1:0] xsum;
`endif
    logic              last;
    logic [BYTE_W-1:0] data;
  } btb_entry_t;

endpackage

// File: rtl/btb_skid_buf.sv
// Two-entry registered valid/ready buffer of btb_entry_t.
// push_ready_o comes from the occupancy register only, so it never depends on pop_ready_i.
module btb_skid_buf
  import kyber_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid_i,
  input  btb_entry_t push_entry_i,
  output logic       push_ready_o,
  output logic       pop_valid_o,
  input  logic       pop_ready_i,
  output btb_entry_t pop_entry_o
);

  btb_entry_t head_q, head_d;
  btb_entry_t tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       push;
  logic       pop;

  assign push_ready_o = (count_q != 2'd2);
  assign pop_valid_o  = (count_q != 2'd0);
  assign pop_entry_o  = pop_valid_o ? head_q : '0;
  assign push         = push_valid_i && push_ready_o;
  assign pop          = pop_valid_o && pop_ready_i;

  // Next-state: head always holds the oldest entry; a push with a pop at one entry replaces the head.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = push_entry_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = push_entry_i;
        end else if (push) begin
          tail_d  = push_entry_i;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  // Storage registers, flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bits_to_bytes_stream.sv
// Streaming BitsToBytes packer: LSB-first bit beats in, framed bytes out via a 2-entry skid buffer.
// Optional feature macro BTB_XOR_EN adds the frame_xor port carrying the XOR of all frame bytes.
module bits_to_bytes_stream
  import kyber_pkg::*;
#(
  parameter int IN_W       = 1,
  parameter int BYTE_COUNT = KYBER_N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_bits,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_byte,
  output logic            out_last,
`ifdef BTB_XOR_EN
  output logic [7:0]      frame_xor,
`endif
  output logic            busy
);

  localparam int IDX_W = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;

  if (!(IN_W == 1 || IN_W == 2 || IN_W == 4 || IN_W == 8)) begin : g_bad_in_w
    $error("bits_to_bytes_stream: IN_W must be 1, 2, 4 or 8");
  end
  if (BYTE_COUNT < 1) begin : g_bad_byte_count
    $error("bits_to_bytes_stream: BYTE_COUNT must be at least 1");
  end

  logic [BYTE_W-1:0] acc_q, acc_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  btb_state_e        state_q, state_d;
  logic              newbeat_q, newbeat_d;
  logic [1:0]        lasts_q, lasts_d;

  logic              skid_ready;
  logic              accept;
  logic              complete;
  logic              idx_is_last;
  logic              push_last;
  logic              pop_last;
  logic [3:0]        cnt_sum;
  logic [BYTE_W-1:0] in_ext;
  logic [BYTE_W-1:0] merged;
  btb_entry_t        push_entry;
  btb_entry_t        out_entry;

  assign in_ready    = skid_ready && !rst;
  assign accept      = in_valid && in_ready;
  assign cnt_sum     = {1'b0, bit_cnt_q} + 4'(IN_W);
  assign complete    = accept && (cnt_sum == 4'd8);
  assign idx_is_last = (byte_idx_q == IDX_W'(BYTE_COUNT - 1));
  assign push_last   = complete && idx_is_last;
  assign in_ext      = BYTE_W'(in_bits);
  assign merged      = acc_q | (in_ext << bit_cnt_q);
  assign pop_last    = out_valid && out_ready && out_last;
  assign out_byte    = out_entry.data;
  assign out_last    = out_entry.last;

`ifdef BTB_XOR_EN
  logic [BYTE_W-1:0] xor_run_q, xor_run_d;

  // Running XOR of bytes pushed so far in the frame; restarts once the last byte is pushed.
  always_comb begin
    xor_run_d = xor_run_q;
    if (complete) begin
      xor_run_d = push_last ? '0 : (xor_run_q ^ merged);
    end
  end

  // XOR accumulator register.
  always_ff @(posedge clk) begin
    if (rst) xor_run_q <= '0;
    else     xor_run_q <= xor_run_d;
  end

  assign push_entry = '{xsum: xor_run_q ^ merged, last: idx_is_last, data: merged};
  assign frame_xor  = (out_valid && out_entry.last) ? out_entry.xsum : 8'h00;
`else
  assign push_entry = '{last: idx_is_last, data: merged};
`endif

  btb_skid_buf u_skid (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (complete),
    .push_entry_i (push_entry),
    .push_ready_o (skid_ready),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .pop_entry_o  (out_entry)
  );

  // Accumulator, bit position and byte index within the frame.
  always_comb begin
    acc_d      = acc_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    if (accept) begin
      bit_cnt_d = cnt_sum[2:0];
      acc_d     = merged;
    end
    if (complete) begin
      acc_d      = '0;
      byte_idx_d = idx_is_last ? '0 : (byte_idx_q + IDX_W'(1));
    end
  end

  // Number of last-flagged bytes still waiting in the skid buffer.
  always_comb begin
    lasts_d = lasts_q;
    case ({push_last, pop_last})
      2'b10:   lasts_d = lasts_q + 2'd1;
      2'b01:   lasts_d = lasts_q - 2'd1;
      default: lasts_d = lasts_q;
    endcase
  end

  // Framing FSM next state: DRAIN waits for the out_last handshake, resuming PACK if the next frame began.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = push_last ? DRAIN : PACK;
      end
      PACK: begin
        if (push_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop_last) begin
          if (lasts_q == 2'd2 || push_last) state_d = DRAIN;
          else if (newbeat_q || accept)     state_d = PACK;
          else                              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Remembers that next-frame bits were taken while the previous frame is still draining.
  always_comb begin
    newbeat_d = 1'b0;
    if (state_q == DRAIN && state_d == DRAIN) begin
      newbeat_d = newbeat_q;
      if (accept) newbeat_d = !push_last;
    end
  end

  // FSM output: a frame is in progress whenever the FSM is not idle.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // State registers; reset discards any partial byte and aborts the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= '0;
      state_q    <= IDLE;
      newbeat_q  <= 1'b0;
      lasts_q    <= 2'd0;
    end else begin
      acc_q      <= acc_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      state_q    <= state_d;
      newbeat_q  <= newbeat_d;
      lasts_q    <= lasts_d;
    end
  end

endmodule

// File: tb/tb_bits_to_bytes_stream.sv
// Bench for bits_to_bytes_stream: four instances (IN_W 1/8/4/2) checked against a byte scoreboard.
// Frame XOR checks are compiled in when BTB_XOR_EN is defined.
module tb_bits_to_bytes_stream;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // instance 0: IN_W=1, BYTE_COUNT=4
  logic       aInValid, aInReady, aInBits, aOutValid, aOutReady, aOutLast, aBusy;
  logic [7:0] aOutByte, aFrameXor;
  // instance 1: IN_W=8, BYTE_COUNT=4
  logic       bInValid, bInReady, bOutValid, bOutReady, bOutLast, bBusy;
  logic [7:0] bInBits, bOutByte, bFrameXor;
  // instance 2: IN_W=4, BYTE_COUNT=4
  logic       cInValid, cInReady, cOutValid, cOutReady, cOutLast, cBusy;
  logic [3:0] cInBits;
  logic [7:0] cOutByte, cFrameXor;
  // instance 3: IN_W=2, BYTE_COUNT=2
  logic       dInValid, dInReady, dOutValid, dOutReady, dOutLast, dBusy;
  logic [1:0] dInBits;
  logic [7:0] dOutByte, dFrameXor;

  bits_to_bytes_stream #(.IN_W(1), .BYTE_COUNT(4)) dutA (
    .clk(clk), .rst(rst), .in_valid(aInValid), .in_ready(aInReady), .in_bits(aInBits),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_byte(aOutByte), .out_last(aOutLast),
`ifdef BTB_XOR_EN
    .frame_xor(aFrameXor),
`endif
    .busy(aBusy));

  bits_to_bytes_stream #(.IN_W(8), .BYTE_COUNT(4)) dutB (
    .clk(clk), .rst(rst), .in_valid(bInValid), .in_ready(bInReady), .in_bits(bInBits),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_byte(bOutByte), .out_last(bOutLast),
`ifdef BTB_XOR_EN
    .frame_xor(bFrameXor),
`endif
    .busy(bBusy));

  bits_to_bytes_stream #(.IN_W(4), .BYTE_COUNT(4)) dutC (
    .clk(clk), .rst(rst), .in_valid(cInValid), .in_ready(cInReady), .in_bits(cInBits),
    .out_valid(cOutValid), .out_ready(cOutReady), .out_byte(cOutByte), .out_last(cOutLast),
`ifdef BTB_XOR_EN
    .frame_xor(cFrameXor),
`endif
    .busy(cBusy));

  bits_to_bytes_stream #(.IN_W(2), .BYTE_COUNT(2)) dutD (
    .clk(clk), .rst(rst), .in_valid(dInValid), .in_ready(dInReady), .in_bits(dInBits),
    .out_valid(dOutValid), .out_ready(dOutReady), .out_byte(dOutByte), .out_last(dOutLast),
`ifdef BTB_XOR_EN
    .frame_xor(dFrameXor),
`endif
    .busy(dBusy));

`ifndef BTB_XOR_EN
  assign aFrameXor = 8'h00;
  assign bFrameXor = 8'h00;
  assign cFrameXor = 8'h00;
  assign dFrameXor = 8'h00;
`endif

  // scoreboard entries are {expected frame_xor, expected last, expected byte}
  logic [16:0] qA[$];
  logic [16:0] qB[$];
  logic [16:0] qC[$];
  logic [16:0] qD[$];
  logic [7:0]  xorRun[4];
  int          passCount = 0;
  int          checkCount = 0;
  logic        randDone;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
  endtask

  task automatic expectByte(input int inst, input logic [7:0] data, input logic last);
    logic [7:0]  fx;
    logic [16:0] e;
    xorRun[inst] = xorRun[inst] ^ data;
    fx = last ? xorRun[inst] : 8'h00;
    if (last) xorRun[inst] = 8'h00;
    e = {fx, last, data};
    case (inst)
      0:       qA.push_back(e);
      1:       qB.push_back(e);
      2:       qC.push_back(e);
      default: qD.push_back(e);
    endcase
  endtask

  task automatic popCheck(input int inst, input logic [7:0] data, input logic last, input logic [7:0] fx);
    logic [16:0] e;
    bit          have;
    have = 0;
    e = '0;
    case (inst)
      0:       if (qA.size() > 0) begin e = qA.pop_front(); have = 1; end
      1:       if (qB.size() > 0) begin e = qB.pop_front(); have = 1; end
      2:       if (qC.size() > 0) begin e = qC.pop_front(); have = 1; end
      default: if (qD.size() > 0) begin e = qD.pop_front(); have = 1; end
    endcase
    if (!have) begin
      checkOutput($sformatf("inst%0d_unexpected_byte_%0h", inst, data), 32'd1, 32'd0);
    end else begin
      checkOutput($sformatf("inst%0d_byte", inst), 32'(data), 32'(e[7:0]));
      checkOutput($sformatf("inst%0d_last", inst), 32'(last), 32'(e[8]));
`ifdef BTB_XOR_EN
      checkOutput($sformatf("inst%0d_frame_xor", inst), 32'(fx), 32'(e[16:9]));
`else
      if (fx !== 8'h00) $error("[TB] FAIL inst%0d_frame_xor_tieoff observed=0x%0h required=0x0", inst, fx);
`endif
    end
  endtask

  // scoreboard monitors: compare every handshaken byte on the falling edge
  always @(negedge clk) if (!rst && aOutValid && aOutReady) popCheck(0, aOutByte, aOutLast, aFrameXor);
  always @(negedge clk) if (!rst && bOutValid && bOutReady) popCheck(1, bOutByte, bOutLast, bFrameXor);
  always @(negedge clk) if (!rst && cOutValid && cOutReady) popCheck(2, cOutByte, cOutLast, cFrameXor);
  always @(negedge clk) if (!rst && dOutValid && dOutReady) popCheck(3, dOutByte, dOutLast, dFrameXor);

  task automatic setIn(input int inst, input logic v, input logic [7:0] beat);
    case (inst)
      0:       begin aInValid = v; aInBits = beat[0];   end
      1:       begin bInValid = v; bInBits = beat;      end
      2:       begin cInValid = v; cInBits = beat[3:0]; end
      default: begin dInValid = v; dInBits = beat[1:0]; end
    endcase
  endtask

  function automatic logic getReady(input int inst);
    case (inst)
      0:       return aInReady;
      1:       return bInReady;
      2:       return cInReady;
      default: return dInReady;
    endcase
  endfunction

  // drive one beat and return #1 after the edge that accepted it (valid left high)
  task automatic applyStimulus(input int inst, input logic [7:0] beat, output int waited);
    logic rdy;
    bit   taken;
    waited = 0;
    taken  = 0;
    setIn(inst, 1'b1, beat);
    while (!taken && waited < 100) begin
      @(negedge clk);
      rdy = getReady(inst);
      @(posedge clk);
      #1;
      if (rdy) taken = 1;
      else     waited++;
    end
    if (!taken) checkOutput($sformatf("inst%0d_accept_timeout", inst), 32'd0, 32'd1);
  endtask

  task automatic sendByte(input int inst, input int w, input logic [7:0] data, output int waited);
    int wt;
    logic [7:0] mask;
    logic [7:0] beat;
    waited = 0;
    mask = 8'((1 << w) - 1);
    for (int k = 0; k < 8 / w; k++) begin
      beat = (data >> (k * w)) & mask;
      applyStimulus(inst, beat, wt);
      waited += wt;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((qA.size() + qB.size() + qC.size() + qD.size()) != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain_pending", 32'(qA.size() + qB.size() + qC.size() + qD.size()), 32'd0);
  endtask

  initial begin
    logic        t1[8];
    logic        t4[8];
    logic [7:0]  frameB[4];
    logic [31:0] rb;
    logic [7:0]  mb[4];
    int          w;
    int          tot;

    t1 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    t4 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    frameB = '{8'h49, 8'h8B, 8'h0B, 8'hFF};
    for (int i = 0; i < 4; i++) xorRun[i] = 8'h00;
    setIn(0, 1'b0, 8'h0); setIn(1, 1'b0, 8'h0); setIn(2, 1'b0, 8'h0); setIn(3, 1'b0, 8'h0);
    aOutReady = 1'b1; bOutReady = 1'b1; cOutReady = 1'b1; dOutReady = 1'b1;
    randDone = 1'b0;
    rst = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready_low", 32'(aInReady), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready_high", 32'(aInReady), 32'd1);
    checkOutput("rst_out_valid", 32'(aOutValid), 32'd0);
    checkOutput("rst_out_byte", 32'(aOutByte), 32'd0);
    checkOutput("rst_out_last", 32'(aOutLast), 32'd0);
    checkOutput("rst_busy", 32'(aBusy), 32'd0);
`ifdef BTB_XOR_EN
    checkOutput("rst_frame_xor", 32'(bFrameXor), 32'd0);
`endif
    @(posedge clk);
    #1;

    // single bits LSB first -> 0x49, valid one cycle after the eighth beat
    $display("[TB] IN_W=1 single byte");
    expectByte(0, 8'h49, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) checkOutput("t1_no_early_valid", 32'(aOutValid), 32'd0);
      applyStimulus(0, {7'h0, t1[i]}, w);
    end
    setIn(0, 1'b0, 8'h0);
    checkOutput("t1_valid_latency", 32'(aOutValid), 32'd1);
    checkOutput("t1_out_byte", 32'(aOutByte), 32'h49);

    // full-width beats back-to-back, in_ready never drops
    $display("[TB] IN_W=8 full frame");
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      expectByte(1, frameB[i], i == 3);
      sendByte(1, 8, frameB[i], w);
      tot += w;
    end
    setIn(1, 1'b0, 8'h0);
    checkOutput("t2_in_ready_stall_cycles", 32'(tot), 32'd0);
    checkOutput("t2_last_on_ff", 32'(bOutLast), 32'd1);
    checkOutput("t2_busy_draining", 32'(bBusy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t2_busy_after_frame", 32'(bBusy), 32'd0);

    // backpressure: two bytes held, input stalls, then drain in order
    $display("[TB] IN_W=4 backpressure");
    cOutReady = 1'b0;
    expectByte(2, 8'hA5, 1'b0);
    expectByte(2, 8'h3C, 1'b0);
    expectByte(2, 8'h97, 1'b0);
    expectByte(2, 8'h12, 1'b1);
    sendByte(2, 4, 8'hA5, w);
    sendByte(2, 4, 8'h3C, w);
    setIn(2, 1'b1, 8'h07);
    @(negedge clk);
    checkOutput("t3_in_ready_full", 32'(cInReady), 32'd0);
    checkOutput("t3_head_byte", 32'(cOutByte), 32'hA5);
    repeat (19) @(negedge clk);
    checkOutput("t3_in_ready_still_full", 32'(cInReady), 32'd0);
    checkOutput("t3_head_byte_held", 32'(cOutByte), 32'hA5);
    checkOutput("t3_head_valid_held", 32'(cOutValid), 32'd1);
    @(posedge clk);
    #1 cOutReady = 1'b1;
    sendByte(2, 4, 8'h97, w);
    sendByte(2, 4, 8'h12, w);
    setIn(2, 1'b0, 8'h0);
    waitDrain();

    // reset mid-byte discards partial bits
    $display("[TB] reset mid-frame");
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h01, w);
    setIn(0, 1'b0, 8'h0);
    checkOutput("t4_busy_before_rst", 32'(aBusy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) xorRun[i] = 8'h00;
    checkOutput("t4_busy_after_rst", 32'(aBusy), 32'd0);
    checkOutput("t4_valid_after_rst", 32'(aOutValid), 32'd0);
    expectByte(0, 8'hFE, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(0, {7'h0, t4[i]}, w);
    setIn(0, 1'b0, 8'h0);
    checkOutput("t4_out_byte", 32'(aOutByte), 32'hFE);

    // two abutting 2-byte frames with IN_W=2
    $display("[TB] IN_W=2 abutted frames");
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      expectByte(3, frameB[i], (i % 2) == 1);
      for (int k = 0; k < 4; k++) begin
        applyStimulus(3, (frameB[i] >> (2 * k)) & 8'h03, w);
        tot += w;
        if (i == 2 && k == 0) checkOutput("t5_busy_at_boundary", 32'(dBusy), 32'd1);
      end
    end
    setIn(3, 1'b0, 8'h0);
    checkOutput("t5_stall_cycles", 32'(tot), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t5_busy_after_frames", 32'(dBusy), 32'd0);

    // random frames through IN_W=4 against a software BitsToBytes model, random out_ready
    $display("[TB] random frames");
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          rb = $urandom;
          for (int j = 0; j < 4; j++) mb[j] = 8'h00;
          for (int i = 0; i < 32; i++) mb[i / 8][i % 8] = mb[i / 8][i % 8] | rb[i];
          for (int j = 0; j < 4; j++) expectByte(2, mb[j], j == 3);
          for (int k = 0; k < 8; k++) applyStimulus(2, {4'h0, rb[4 * k +: 4]}, w);
        end
        setIn(2, 1'b0, 8'h0);
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1 cOutReady = 1'($urandom_range(0, 1));
        end
      end
    join
    cOutReady = 1'b1;
    waitDrain();
    checkOutput("end_busy_c", 32'(cBusy), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
